// File: rtl/hci_cmd_sequencer.sv
// PIO command sequencer: pops descriptors, reads the DAT entry, drives one transfer and posts one response.
// Optional XFER_WAIT watchdog is enabled by defining HCI_CMD_TIMEOUT_EN.
module hci_cmd_sequencer #(
    parameter int unsigned DatDepth      = 128,
    parameter int unsigned CmdFifoWidth  = 64,
    parameter int unsigned RespFifoWidth = 32,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmdrst_i,
    input  logic                          cmd_fifo_rvalid_i,
    output logic                          cmd_fifo_rready_o,
    input  logic [CmdFifoWidth-1:0]       cmd_fifo_rdata_i,
    output logic                          dat_read_valid_o,
    output logic [$clog2(DatDepth)-1:0]   dat_index_o,
    input  logic [63:0]                   dat_rdata_i,
    output logic                          xfer_req_o,
    input  logic                          xfer_ack_i,
    output logic [6:0]                    xfer_addr_o,
    output logic                          xfer_rnw_o,
    output logic [15:0]                   xfer_len_o,
    input  logic                          xfer_done_i,
    input  logic [3:0]                    xfer_status_i,
    output logic                          xfer_abort_o,
    output logic                          resp_fifo_wvalid_o,
    input  logic                          resp_fifo_wready_i,
    output logic [RespFifoWidth-1:0]      resp_fifo_wdata_o,
    output logic                          busy_o
);

    localparam int unsigned IdxW        = $clog2(DatDepth);
    localparam logic [3:0]  StatusParam = 4'h6;
    localparam logic [3:0]  StatusTmo   = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        DAT_RD,
        DAT_WAIT,
        XFER_REQ,
        XFER_WAIT,
        RESP
    } state_e;

    state_e      state;
    logic [2:0]  attr_q;
    logic [3:0]  tid_q;
    logic        rnw_q;
    logic [6:0]  dev_q;
    logic [15:0] len_q;
    logic        timeout_c;

    function automatic logic [RespFifoWidth-1:0] resp_word(input logic [3:0] status,
                                                            input logic [3:0] tid,
                                                            input logic [15:0] len);
        return RespFifoWidth'({status, tid, 8'h00, len});
    endfunction

    // Descriptor fields and DAT bits the sequencer does not consume.
    logic unused_bits;
    assign unused_bits = ^{cmd_fifo_rdata_i[15:8], cmd_fifo_rdata_i[47:23],
                           dat_rdata_i[63:23], dat_rdata_i[15:0]};

`ifdef HCI_CMD_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
    logic [15:0] wait_cnt;

    // Counter is zero on every XFER_WAIT entry and counts cycles spent waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (cmdrst_i || (state != XFER_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_c = (wait_cnt == TimeoutLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TimeoutCycles);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            attr_q             <= '0;
            tid_q              <= '0;
            rnw_q              <= 1'b0;
            dev_q              <= '0;
            len_q              <= '0;
            cmd_fifo_rready_o  <= 1'b0;
            dat_read_valid_o   <= 1'b0;
            dat_index_o        <= '0;
            xfer_req_o         <= 1'b0;
            xfer_addr_o        <= '0;
            xfer_rnw_o         <= 1'b0;
            xfer_len_o         <= '0;
            xfer_abort_o       <= 1'b0;
            resp_fifo_wvalid_o <= 1'b0;
            resp_fifo_wdata_o  <= '0;
            busy_o             <= 1'b0;
        end else begin
            cmd_fifo_rready_o <= 1'b0;
            dat_read_valid_o  <= 1'b0;
            xfer_abort_o      <= 1'b0;

            // Queue soft reset overrides everything; an in-flight transfer is aborted.
            if (cmdrst_i) begin
                state              <= IDLE;
                busy_o             <= 1'b0;
                xfer_req_o         <= 1'b0;
                resp_fifo_wvalid_o <= 1'b0;
                xfer_abort_o       <= (state == XFER_REQ) || (state == XFER_WAIT);
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cmd_fifo_rvalid_i) begin
                            cmd_fifo_rready_o <= 1'b1;
                            attr_q            <= cmd_fifo_rdata_i[2:0];
                            tid_q             <= cmd_fifo_rdata_i[6:3];
                            rnw_q             <= cmd_fifo_rdata_i[7];
                            dev_q             <= cmd_fifo_rdata_i[22:16];
                            len_q             <= cmd_fifo_rdata_i[63:48];
                            busy_o            <= 1'b1;
                            state             <= DECODE;
                        end
                    end
                    DECODE: begin
                        if ((attr_q != 3'd0) || (32'(dev_q) >= DatDepth)) begin
                            resp_fifo_wdata_o  <= resp_word(StatusParam, tid_q, len_q);
                            resp_fifo_wvalid_o <= 1'b1;
                            state              <= RESP;
                        end else begin
                            dat_read_valid_o <= 1'b1;
                            dat_index_o      <= IdxW'(dev_q);
                            state            <= DAT_RD;
                        end
                    end
                    DAT_RD: begin
                        state <= DAT_WAIT;
                    end
                    DAT_WAIT: begin
                        xfer_addr_o <= dat_rdata_i[22:16];
                        xfer_rnw_o  <= rnw_q;
                        xfer_len_o  <= len_q;
                        xfer_req_o  <= 1'b1;
                        state       <= XFER_REQ;
                    end
                    XFER_REQ: begin
                        if (xfer_ack_i) begin
                            xfer_req_o <= 1'b0;
                            state      <= XFER_WAIT;
                        end
                    end
                    XFER_WAIT: begin
                        // A done in the same cycle as the watchdog expiry takes precedence.
                        if (xfer_done_i) begin
                            resp_fifo_wdata_o  <= resp_word(xfer_status_i, tid_q, len_q);
                            resp_fifo_wvalid_o <= 1'b1;
                            state              <= RESP;
                        end else if (timeout_c) begin
                            xfer_abort_o       <= 1'b1;
                            resp_fifo_wdata_o  <= resp_word(StatusTmo, tid_q, len_q);
                            resp_fifo_wvalid_o <= 1'b1;
                            state              <= RESP;
                        end
                    end
                    RESP: begin
                        if (resp_fifo_wready_i) begin
                            resp_fifo_wvalid_o <= 1'b0;
                            busy_o             <= 1'b0;
                            state              <= IDLE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hci_cmd_sequencer.sv
// Directed bench for hci_cmd_sequencer with FIFO, DAT and transfer-engine models and scoreboards.
module tb_hci_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmdrst;
    logic        cmd_rvalid;
    logic        cmd_rready;
    logic [63:0] cmd_rdata;
    logic        dat_rd;
    logic [6:0]  dat_idx;
    logic [63:0] dat_rdata;
    logic        xreq;
    logic        xack;
    logic [6:0]  xaddr;
    logic        xrnw;
    logic [15:0] xlen;
    logic        xdone;
    logic [3:0]  xstatus;
    logic        xabort;
    logic        resp_valid;
    logic        wready;
    logic [31:0] wdata;
    logic        busy;

    always #5 clk = ~clk;

    hci_cmd_sequencer #(
        .DatDepth      (128),
        .CmdFifoWidth  (64),
        .RespFifoWidth (32),
        .TimeoutCycles (16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .cmdrst_i           (cmdrst),
        .cmd_fifo_rvalid_i  (cmd_rvalid),
        .cmd_fifo_rready_o  (cmd_rready),
        .cmd_fifo_rdata_i   (cmd_rdata),
        .dat_read_valid_o   (dat_rd),
        .dat_index_o        (dat_idx),
        .dat_rdata_i        (dat_rdata),
        .xfer_req_o         (xreq),
        .xfer_ack_i         (xack),
        .xfer_addr_o        (xaddr),
        .xfer_rnw_o         (xrnw),
        .xfer_len_o         (xlen),
        .xfer_done_i        (xdone),
        .xfer_status_i      (xstatus),
        .xfer_abort_o       (xabort),
        .resp_fifo_wvalid_o (resp_valid),
        .resp_fifo_wready_i (wready),
        .resp_fifo_wdata_o  (wdata),
        .busy_o             (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0, n_dat = 0, n_ack = 0, n_abort = 0, n_resp = 0, n_req_cyc = 0;
    int cyc = 0, ack_cyc = 0, abort_cyc = 0;
    int resp_target = 0;

    logic [63:0] cmd_q[$];
    logic [31:0] exp_resp[$];
    logic [23:0] exp_xfer[$];
    logic [6:0]  dat_mem[128];

    bit         eng_auto = 1'b1;
    bit         eng_hang = 1'b0;
    bit         eng_busy = 1'b0;
    int         eng_delay = 2;
    int         eng_wait = 0;
    logic [3:0] eng_status = 4'h0;
    bit         dat_hold = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_refresh();
        cmd_rvalid = (cmd_q.size() > 0);
        cmd_rdata  = cmd_rvalid ? cmd_q[0] : 64'h0;
    endtask

    task automatic push_cmd(input logic [63:0] d);
        cmd_q.push_back(d);
        fifo_refresh();
    endtask

    // Junk in the unused descriptor bits must not affect anything.
    function automatic logic [63:0] desc(input logic [2:0] attr, input logic [3:0] tid,
                                         input logic rnw, input logic [6:0] idx,
                                         input logic [15:0] len);
        logic [63:0] d;
        d        = 64'h0000_BEEF_0000_AA00;
        d[2:0]   = attr;
        d[6:3]   = tid;
        d[7]     = rnw;
        d[22:16] = idx;
        d[63:48] = len;
        return d;
    endfunction

    task automatic wait_resp(input string tag);
        int k;
        k = 0;
        while ((n_resp < resp_target) && (k < 300)) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check(tag, 64'(n_resp), 64'(resp_target));
    endtask

    always @(posedge clk) cyc++;

    // Command FIFO, DAT, transfer engine and response sink models.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_rready) begin
                n_pop++;
                if (cmd_q.size() > 0) void'(cmd_q.pop_front());
                fifo_refresh();
            end
            if (dat_rd) begin
                n_dat++;
                dat_rdata = {41'h0, dat_mem[dat_idx], 16'hC0DE};
                dat_hold  = 1'b1;
            end else if (dat_hold) begin
                dat_hold = 1'b0;
            end else begin
                dat_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (xreq) n_req_cyc++;
            if (xabort) begin
                n_abort++;
                abort_cyc = cyc;
                eng_busy  = 1'b0;
            end
            if (xdone) xdone = 1'b0;
            if (xack) begin
                xack     = 1'b0;
                eng_busy = 1'b1;
                eng_wait = eng_delay;
            end else if (xreq && eng_auto && !eng_busy) begin
                xack = 1'b1;
                n_ack++;
                ack_cyc = cyc;
                if (exp_xfer.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL xfer_unexpected: observed %0h expected none", {xaddr, xrnw, xlen});
                end else begin
                    check("xfer_fields", 64'({xaddr, xrnw, xlen}), 64'(exp_xfer.pop_front()));
                end
            end else if (eng_busy && !eng_hang) begin
                if (eng_wait == 0) begin
                    xdone    = 1'b1;
                    xstatus  = eng_status;
                    eng_busy = 1'b0;
                end else begin
                    eng_wait--;
                end
            end
            if (resp_valid && wready) begin
                n_resp++;
                if (exp_resp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL resp_unexpected: observed %0h expected none", wdata);
                end else begin
                    check("resp_data", 64'(wdata), 64'(exp_resp.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int base_pop, base_dat, base_req, base_abort, k;
        for (int i = 0; i < 128; i++) dat_mem[i] = 7'(i * 3 + 1);
        dat_mem[3] = 7'h2A;
        rst_n = 1'b0; cmdrst = 1'b0; wready = 1'b1;
        xack = 1'b0; xdone = 1'b0; xstatus = 4'h0;
        cmd_rvalid = 1'b0; cmd_rdata = 64'h0; dat_rdata = 64'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({busy, cmd_rready, dat_rd, xreq, xabort, resp_valid}), 64'h0);
        check("reset_data", 64'({xaddr, xrnw, xlen, dat_idx}), 64'h0);
        check("reset_wdata", 64'(wdata), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic read command, with IDLE-to-request latency
        exp_xfer.push_back({7'h2A, 1'b1, 16'd8});
        exp_resp.push_back(32'h0500_0008);
        resp_target++;
        push_cmd(desc(3'd0, 4'd5, 1'b1, 7'd3, 16'd8));
        repeat (3) @(posedge clk);
        #1;
        check("latency_pre", 64'(xreq), 64'h0);
        @(posedge clk);
        #1;
        check("latency_req", 64'(xreq), 64'h1);
        wait_resp("basic_resp_count");
        check("basic_pops", 64'(n_pop), 64'd1);
        check("basic_dat_reads", 64'(n_dat), 64'd1);
        check("basic_idle", 64'(busy), 64'h0);

        // Bad attr: parameter error without DAT read or transfer
        base_dat = n_dat;
        base_req = n_req_cyc;
        exp_resp.push_back(32'h6200_1234);
        resp_target++;
        push_cmd(desc(3'd1, 4'd2, 1'b0, 7'd9, 16'h1234));
        wait_resp("param_resp_count");
        check("param_no_dat", 64'(n_dat), 64'(base_dat));
        check("param_no_req", 64'(n_req_cyc), 64'(base_req));

        // Two queued commands behind a full response FIFO
        wready   = 1'b0;
        base_pop = n_pop;
        exp_xfer.push_back({dat_mem[4], 1'b0, 16'h0010});
        exp_xfer.push_back({dat_mem[5], 1'b1, 16'h0020});
        exp_resp.push_back(32'h0100_0010);
        exp_resp.push_back(32'h0200_0020);
        resp_target += 2;
        push_cmd(desc(3'd0, 4'd1, 1'b0, 7'd4, 16'h0010));
        push_cmd(desc(3'd0, 4'd2, 1'b1, 7'd5, 16'h0020));
        k = 0;
        while (!resp_valid && (k < 50)) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (10) @(posedge clk);
        #1;
        check("stall_pops", 64'(n_pop), 64'(base_pop + 1));
        check("stall_wvalid", 64'(resp_valid), 64'h1);
        check("stall_wdata", 64'(wdata), 64'h0100_0010);
        wready = 1'b1;
        wait_resp("stall_resp_count");
        check("stall_pops_after", 64'(n_pop), 64'(base_pop + 2));

        // Soft reset during XFER_WAIT, then held across a pending command
        eng_hang   = 1'b1;
        base_abort = n_abort;
        exp_xfer.push_back({dat_mem[6], 1'b0, 16'h0007});
        k = n_ack;
        push_cmd(desc(3'd0, 4'd3, 1'b0, 7'd6, 16'h0007));
        while ((n_ack == k) && (cyc < 5000)) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("cmdrst_busy_pre", 64'(busy), 64'h1);
        cmdrst = 1'b1;
        @(posedge clk);
        #1;
        check("cmdrst_abort", 64'(xabort), 64'h1);
        check("cmdrst_idle", 64'(busy), 64'h0);
        check("cmdrst_no_wvalid", 64'(resp_valid), 64'h0);
        base_pop = n_pop;
        push_cmd(desc(3'd0, 4'd4, 1'b1, 7'd7, 16'h0003));
        @(posedge clk);
        #1;
        check("cmdrst_abort_pulse", 64'(xabort), 64'h0);
        repeat (5) @(posedge clk);
        #1;
        check("cmdrst_held_no_pop", 64'(n_pop), 64'(base_pop));
        check("cmdrst_held_idle", 64'(busy), 64'h0);
        eng_hang = 1'b0;
        exp_xfer.push_back({dat_mem[7], 1'b1, 16'h0003});
        exp_resp.push_back(32'h0400_0003);
        resp_target++;
        cmdrst = 1'b0;
        wait_resp("cmdrst_resume_count");
        check("cmdrst_abort_count", 64'(n_abort), 64'(base_abort + 1));

        // Zero length is transferred unchanged; engine status reported
        eng_status = 4'h3;
        exp_xfer.push_back({dat_mem[0], 1'b0, 16'h0000});
        exp_resp.push_back(32'h3F00_0000);
        resp_target++;
        push_cmd(desc(3'd0, 4'hF, 1'b0, 7'd0, 16'h0000));
        wait_resp("len0_resp_count");
        eng_status = 4'h0;

        // Asynchronous reset while the request is outstanding
        eng_auto = 1'b0;
        push_cmd(desc(3'd0, 4'd6, 1'b0, 7'd8, 16'h0011));
        k = 0;
        while (!xreq && (k < 30)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("areset_req_seen", 64'(xreq), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_ctrl", 64'({busy, cmd_rready, dat_rd, xreq, xabort, resp_valid}), 64'h0);
        check("areset_data", 64'({xaddr, xrnw, xlen, dat_idx}), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        eng_auto = 1'b1;
        exp_xfer.push_back({7'h2A, 1'b1, 16'h0040});
        exp_resp.push_back(32'h0900_0040);
        resp_target++;
        push_cmd(desc(3'd0, 4'd9, 1'b1, 7'd3, 16'h0040));
        wait_resp("areset_after_count");

`ifdef HCI_CMD_TIMEOUT_EN
        // Engine never completes: watchdog aborts and reports status A
        eng_hang   = 1'b1;
        base_abort = n_abort;
        exp_xfer.push_back({dat_mem[10], 1'b0, 16'h0005});
        exp_resp.push_back(32'hA700_0005);
        resp_target++;
        push_cmd(desc(3'd0, 4'd7, 1'b0, 7'd10, 16'h0005));
        wait_resp("timeout_resp_count");
        check("timeout_abort_count", 64'(n_abort), 64'(base_abort + 1));
        check("timeout_abort_cycle", 64'(abort_cyc - ack_cyc), 64'd17);
        eng_hang = 1'b0;
`endif

        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
        check("xfer_queue_drained", 64'(exp_xfer.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
